commit_ctrl_n: RTL and testbench

//  N-way commit/exception controller at the tail of the back end (after wb). Picks the oldest

---
 rtl/commit_ctrl_n.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_commit_ctrl_n.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_ctrl_n.sv
// -----------------------------------------------------------------------------
// commit_ctrl_n
//
// Commit / exception controller sitting after write-back. Each cycle it looks
// at ISSUE_WIDTH commit slots (slot 0 oldest). It finds the oldest slot that
// carries an exception, an interrupt, an ertn or an idle, and retires only the
// slots older than that one. Exceptions and ertn are reported to the CSR block
// combinationally, and the pipeline redirect (flush + new_pc) is registered
// one cycle later. After an idle retires the controller parks in IDLE_WAIT
// with the whole pipe paused until an interrupt arrives. A free-running
// counter accumulates the number of retired instructions.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   slot_*            per-slot instruction info (valid, pc, exception flags,
//                     per-source causes, priv/ertn/idle, badv, rf write req);
//                     slot_csr_we applies to slot 0 only
//   crmd_*, ecfg_lie, estat_is, era, eentry
//                     CSR state used for interrupts and redirect targets
//   branch_flush, branch_target
//                     mispredict redirect request from the back end
//   pause_req         stall request from stage j (0 .. PIPE_WIDTH-2)
//   commit_en, rf_we, csr_we
//                     gated retire / write enables
//   exc_*, ertn_valid exception / ertn report to the CSR block
//   flush, new_pc     registered per-stage flush and redirect target
//   pause             per-stage pause mask
//   retired_cnt       retired instruction counter (wraps)
// -----------------------------------------------------------------------------
module commit_ctrl_n #(
    parameter int ISSUE_WIDTH = 2,
    parameter int PIPE_WIDTH  = 8,
    parameter int EXC_SRC     = 6,
    parameter int CNT_W       = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ISSUE_WIDTH-1:0]            slot_valid,
    input  logic [ISSUE_WIDTH*32-1:0]         slot_pc,
    input  logic [ISSUE_WIDTH*EXC_SRC-1:0]    slot_exc,
    input  logic [ISSUE_WIDTH*EXC_SRC*15-1:0] slot_cause,
    input  logic [ISSUE_WIDTH-1:0]            slot_priv,
    input  logic [ISSUE_WIDTH-1:0]            slot_ertn,
    input  logic [ISSUE_WIDTH-1:0]            slot_idle,
    input  logic [ISSUE_WIDTH*32-1:0]         slot_mem_addr,
    input  logic [ISSUE_WIDTH-1:0]            slot_rf_we,
    input  logic                              slot_csr_we,
    input  logic [1:0]                        crmd_plv,
    input  logic                              crmd_ie,
    input  logic [12:0]                       ecfg_lie,
    input  logic [12:0]                       estat_is,
    input  logic [31:0]                       era,
    input  logic [31:0]                       eentry,
    input  logic                              branch_flush,
    input  logic [31:0]                       branch_target,
    input  logic [PIPE_WIDTH-2:0]             pause_req,
    output logic [ISSUE_WIDTH-1:0]            commit_en,
    output logic [ISSUE_WIDTH-1:0]            rf_we,
    output logic                              csr_we,
    output logic                              exc_valid,
    output logic [5:0]                        exc_ecode,
    output logic [8:0]                        exc_esubcode,
    output logic [31:0]                       exc_pc,
    output logic [31:0]                       exc_badv,
    output logic                              ertn_valid,
    output logic [PIPE_WIDTH-1:0]             flush,
    output logic [31:0]                       new_pc,
    output logic [PIPE_WIDTH-1:0]             pause,
    output logic [CNT_W-1:0]                  retired_cnt
);

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_IPE = 6'h0E;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_REDIRECT  = 2'd1,
        ST_IDLE_WAIT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PIPE_WIDTH-1:0]  flush_q, flush_d;
    logic [31:0]            new_pc_q, new_pc_d;
    logic [31:0]            idle_pc_q, idle_pc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // -------------------------------------------------------------------------
    // Per-slot cause selection: highest set source wins; a privileged
    // instruction flagged on source 2 outside PLV0 turns into IPE.
    // -------------------------------------------------------------------------
    logic [ISSUE_WIDTH-1:0]    slot_has_exc;
    logic [ISSUE_WIDTH*15-1:0] slot_sel_cause;

    generate
        for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
            logic [14:0] cause_l;
            logic        src2_l;

            always_comb begin
                cause_l = '0;
                src2_l  = 1'b0;
                for (int s = 0; s < EXC_SRC; s++) begin
                    if (slot_exc[gi*EXC_SRC + s]) begin
                        cause_l = slot_cause[(gi*EXC_SRC + s)*15 +: 15];
                        src2_l  = (s == 2);
                    end
                end
            end

            assign slot_has_exc[gi] = |slot_exc[gi*EXC_SRC +: EXC_SRC];
            assign slot_sel_cause[gi*15 +: 15] =
                (src2_l && slot_priv[gi] && (crmd_plv != 2'd0)) ? {9'd0, ECODE_IPE} : cause_l;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pause mask: highest requesting stage j pauses stages 0..j (thermometer).
    // -------------------------------------------------------------------------
    logic [PIPE_WIDTH-1:0] pause_run;

    generate
        for (genvar gi = 0; gi < PIPE_WIDTH-1; gi++) begin : g_pause
            assign pause_run[gi] = |pause_req[PIPE_WIDTH-2:gi];
        end
    endgenerate
    assign pause_run[PIPE_WIDTH-1] = 1'b0;

    logic commit_blk;
    logic int_pend;

    // A pause reaching wb-1 or wb means the commit stage itself is held.
    assign commit_blk = |pause_run[PIPE_WIDTH-1:PIPE_WIDTH-2];
    assign int_pend   = crmd_ie & (|(ecfg_lie & estat_is));

    // -------------------------------------------------------------------------
    // Oldest-event search and commit gating (only meaningful in RUN).
    // -------------------------------------------------------------------------
    logic        ev_found, ev_exc, ev_ertn, ev_idle;
    logic [14:0] ev_cause;
    logic [31:0] ev_pc, ev_badv;

    always_comb begin
        commit_en = '0;
        ev_found  = 1'b0;
        ev_exc    = 1'b0;
        ev_ertn   = 1'b0;
        ev_idle   = 1'b0;
        ev_cause  = '0;
        ev_pc     = '0;
        ev_badv   = '0;
        if ((state_q == ST_RUN) && !commit_blk) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (slot_valid[i] && !ev_found) begin
                    if ((i == 0) && int_pend) begin
                        // Interrupt is attached to the oldest slot and
                        // overrides whatever else that slot reports.
                        ev_found = 1'b1;
                        ev_exc   = 1'b1;
                        ev_cause = {9'd0, ECODE_INT};
                        ev_pc    = slot_pc[i*32 +: 32];
                        ev_badv  = slot_mem_addr[i*32 +: 32];
                    end else if (slot_has_exc[i]) begin
                        ev_found = 1'b1;
                        ev_exc   = 1'b1;
                        ev_cause = slot_sel_cause[i*15 +: 15];
                        ev_pc    = slot_pc[i*32 +: 32];
                        ev_badv  = slot_mem_addr[i*32 +: 32];
                    end else if (slot_ertn[i]) begin
                        ev_found     = 1'b1;
                        ev_ertn      = 1'b1;
                        ev_pc        = slot_pc[i*32 +: 32];
                        commit_en[i] = 1'b1;
                    end else if (slot_idle[i]) begin
                        ev_found     = 1'b1;
                        ev_idle      = 1'b1;
                        ev_pc        = slot_pc[i*32 +: 32];
                        commit_en[i] = 1'b1;
                    end else begin
                        commit_en[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign rf_we      = commit_en & slot_rf_we;
    assign csr_we     = commit_en[0] & slot_csr_we;
    assign ertn_valid = ev_ertn;
    assign pause      = (state_q == ST_IDLE_WAIT) ? {PIPE_WIDTH{1'b1}} : pause_run;

    always_comb begin
        exc_valid    = 1'b0;
        exc_ecode    = '0;
        exc_esubcode = '0;
        exc_pc       = '0;
        exc_badv     = '0;
        if (state_q == ST_IDLE_WAIT) begin
            if (int_pend) begin
                // Wake-up interrupt returns to the instruction after idle.
                exc_valid = 1'b1;
                exc_ecode = ECODE_INT;
                exc_pc    = idle_pc_q + 32'd4;
            end
        end else if (ev_exc) begin
            exc_valid    = 1'b1;
            exc_ecode    = ev_cause[5:0];
            exc_esubcode = ev_cause[14:6];
            exc_pc       = ev_pc;
            exc_badv     = ev_badv;
        end
    end

    // -------------------------------------------------------------------------
    // Next state: redirect, idle wait, counter.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [CNT_W-1:0] cnt_inc;
        state_d   = state_q;
        flush_d   = '0;
        new_pc_d  = new_pc_q;
        idle_pc_d = idle_pc_q;
        cnt_inc   = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            cnt_inc = cnt_inc + CNT_W'(commit_en[i]);
        end
        cnt_d = cnt_q + cnt_inc;

        case (state_q)
            ST_RUN: begin
                if (ev_exc) begin
                    state_d  = ST_REDIRECT;
                    flush_d  = '1;
                    new_pc_d = eentry;
                end else if (ev_ertn) begin
                    state_d  = ST_REDIRECT;
                    flush_d  = '1;
                    new_pc_d = era;
                end else if (branch_flush) begin
                    // Branch redirect leaves wb alone: the branch itself retires.
                    state_d  = ST_REDIRECT;
                    flush_d  = {1'b0, {(PIPE_WIDTH-1){1'b1}}};
                    new_pc_d = branch_target;
                end else if (ev_idle) begin
                    state_d   = ST_IDLE_WAIT;
                    idle_pc_d = ev_pc;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_RUN;
            end
            ST_IDLE_WAIT: begin
                if (int_pend) begin
                    state_d  = ST_REDIRECT;
                    flush_d  = '1;
                    new_pc_d = eentry;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            flush_q   <= '0;
            new_pc_q  <= '0;
            idle_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
            idle_pc_q <= idle_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign flush       = flush_q;
    assign new_pc      = new_pc_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_commit_ctrl_n.sv
module tb_commit_ctrl_n;

    localparam int IW = 2;
    localparam int PW = 8;
    localparam int ES = 6;
    localparam int CW = 64;
    localparam logic [31:0] EENTRY = 32'h1C00_8000;
    localparam logic [31:0] ERA    = 32'h1C00_4000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [IW-1:0]     slot_valid;
    logic [IW*32-1:0]  slot_pc;
    logic [IW*ES-1:0]  slot_exc;
    logic [IW*ES*15-1:0] slot_cause;
    logic [IW-1:0]     slot_priv, slot_ertn, slot_idle, slot_rf_we;
    logic [IW*32-1:0]  slot_mem_addr;
    logic              slot_csr_we;
    logic [1:0]        crmd_plv;
    logic              crmd_ie;
    logic [12:0]       ecfg_lie, estat_is;
    logic [31:0]       era, eentry, branch_target;
    logic              branch_flush;
    logic [PW-2:0]     pause_req;

    logic [IW-1:0]     commit_en, rf_we;
    logic              csr_we, exc_valid, ertn_valid;
    logic [5:0]        exc_ecode;
    logic [8:0]        exc_esubcode;
    logic [31:0]       exc_pc, exc_badv, new_pc;
    logic [PW-1:0]     flush, pause;
    logic [CW-1:0]     retired_cnt;

    logic [IW-1:0]     w_commit_en, w_rf_we;
    logic              w_csr_we, w_exc_valid, w_ertn_valid;
    logic [5:0]        w_exc_ecode;
    logic [8:0]        w_exc_esubcode;
    logic [31:0]       w_exc_pc, w_exc_badv, w_new_pc;
    logic [PW-1:0]     w_flush, w_pause;
    logic [1:0]        w_retired_cnt;

    int checks = 0;
    int failures = 0;

    commit_ctrl_n #(.ISSUE_WIDTH(IW), .PIPE_WIDTH(PW), .EXC_SRC(ES), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .slot_valid(slot_valid), .slot_pc(slot_pc),
        .slot_exc(slot_exc), .slot_cause(slot_cause), .slot_priv(slot_priv),
        .slot_ertn(slot_ertn), .slot_idle(slot_idle), .slot_mem_addr(slot_mem_addr),
        .slot_rf_we(slot_rf_we), .slot_csr_we(slot_csr_we), .crmd_plv(crmd_plv),
        .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie), .estat_is(estat_is), .era(era),
        .eentry(eentry), .branch_flush(branch_flush), .branch_target(branch_target),
        .pause_req(pause_req), .commit_en(commit_en), .rf_we(rf_we), .csr_we(csr_we),
        .exc_valid(exc_valid), .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode),
        .exc_pc(exc_pc), .exc_badv(exc_badv), .ertn_valid(ertn_valid), .flush(flush),
        .new_pc(new_pc), .pause(pause), .retired_cnt(retired_cnt)
    );

    // Narrow-counter copy: lets the wrap-around be reached in a few commits.
    commit_ctrl_n #(.ISSUE_WIDTH(IW), .PIPE_WIDTH(PW), .EXC_SRC(ES), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .slot_valid(slot_valid), .slot_pc(slot_pc),
        .slot_exc(slot_exc), .slot_cause(slot_cause), .slot_priv(slot_priv),
        .slot_ertn(slot_ertn), .slot_idle(slot_idle), .slot_mem_addr(slot_mem_addr),
        .slot_rf_we(slot_rf_we), .slot_csr_we(slot_csr_we), .crmd_plv(crmd_plv),
        .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie), .estat_is(estat_is), .era(era),
        .eentry(eentry), .branch_flush(branch_flush), .branch_target(branch_target),
        .pause_req(pause_req), .commit_en(w_commit_en), .rf_we(w_rf_we), .csr_we(w_csr_we),
        .exc_valid(w_exc_valid), .exc_ecode(w_exc_ecode), .exc_esubcode(w_exc_esubcode),
        .exc_pc(w_exc_pc), .exc_badv(w_exc_badv), .ertn_valid(w_ertn_valid), .flush(w_flush),
        .new_pc(w_new_pc), .pause(w_pause), .retired_cnt(w_retired_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        slot_valid = '0; slot_pc = '0; slot_exc = '0; slot_cause = '0;
        slot_priv = '0; slot_ertn = '0; slot_idle = '0; slot_mem_addr = '0;
        slot_rf_we = '0; slot_csr_we = 1'b0; crmd_plv = 2'd0; crmd_ie = 1'b0;
        ecfg_lie = '0; estat_is = '0; era = ERA; eentry = EENTRY;
        branch_flush = 1'b0; branch_target = '0; pause_req = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_exc(input int s, input int e, input logic [5:0] code, input logic [8:0] sub);
        slot_exc[s*ES + e] = 1'b1;
        slot_cause[(s*ES + e)*15 +: 15] = {sub, code};
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (flush !== 8'h00) begin failures++; $display("FAIL reset_flush got=%h exp=00", flush); end
        checks++; if (new_pc !== 32'h0) begin failures++; $display("FAIL reset_new_pc got=%h exp=0", new_pc); end
        checks++; if (retired_cnt !== 64'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", retired_cnt); end
        checks++; if (commit_en !== 2'b00 || exc_valid !== 1'b0 || ertn_valid !== 1'b0 || pause !== 8'h00)
            begin failures++; $display("FAIL reset_comb got=%b/%b/%b/%h exp=00/0/0/00", commit_en, exc_valid, ertn_valid, pause); end
        step();
        step();
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_normal_commit();
        apply_reset();
        slot_valid = 2'b11; slot_pc = {32'h1004, 32'h1000}; slot_rf_we = 2'b10; slot_csr_we = 1'b1;
        #1;
        checks++; if (commit_en !== 2'b11) begin failures++; $display("FAIL norm_commit got=%b exp=11", commit_en); end
        checks++; if (rf_we !== 2'b10) begin failures++; $display("FAIL norm_rf_we got=%b exp=10", rf_we); end
        checks++; if (csr_we !== 1'b1) begin failures++; $display("FAIL norm_csr_we got=%b exp=1", csr_we); end
        checks++; if (exc_valid !== 1'b0) begin failures++; $display("FAIL norm_exc got=%b exp=0", exc_valid); end
        step();
        checks++; if (retired_cnt !== 64'd2) begin failures++; $display("FAIL norm_cnt got=%0d exp=2", retired_cnt); end
        checks++; if (flush !== 8'h00) begin failures++; $display("FAIL norm_flush got=%h exp=00", flush); end
        slot_valid = 2'b10;
        #1;
        checks++; if (commit_en !== 2'b10 || csr_we !== 1'b0) begin failures++; $display("FAIL norm_slot1_only got=%b/%b exp=10/0", commit_en, csr_we); end
        step();
        checks++; if (retired_cnt !== 64'd3) begin failures++; $display("FAIL norm_cnt3 got=%0d exp=3", retired_cnt); end
        clear_inputs();
        $display("test_normal_commit done");
    endtask

    task automatic test_exc_slot1();
        apply_reset();
        slot_valid = 2'b11; slot_pc = {32'h1004, 32'h1000}; slot_rf_we = 2'b11;
        slot_mem_addr = {32'hDEAD_0002, 32'h0000_0000};
        set_exc(1, 3, 6'h09, 9'h000);
        #1;
        checks++; if (commit_en !== 2'b01 || rf_we !== 2'b01) begin failures++; $display("FAIL ale_commit got=%b/%b exp=01/01", commit_en, rf_we); end
        checks++; if (exc_valid !== 1'b1 || exc_ecode !== 6'h09) begin failures++; $display("FAIL ale_cause got=%b/%h exp=1/09", exc_valid, exc_ecode); end
        checks++; if (exc_pc !== 32'h1004 || exc_badv !== 32'hDEAD_0002) begin failures++; $display("FAIL ale_pc got=%h/%h exp=1004/dead0002", exc_pc, exc_badv); end
        step();
        checks++; if (flush !== 8'hFF || new_pc !== EENTRY) begin failures++; $display("FAIL ale_redirect got=%h/%h exp=ff/%h", flush, new_pc, EENTRY); end
        checks++; if (commit_en !== 2'b00 || exc_valid !== 1'b0 || rf_we !== 2'b00) begin failures++; $display("FAIL ale_gate got=%b/%b/%b exp=00/0/00", commit_en, exc_valid, rf_we); end
        checks++; if (retired_cnt !== 64'd1) begin failures++; $display("FAIL ale_cnt got=%0d exp=1", retired_cnt); end
        clear_inputs();
        slot_valid = 2'b11; slot_rf_we = 2'b11;
        step();
        checks++; if (flush !== 8'h00 || retired_cnt !== 64'd1) begin failures++; $display("FAIL ale_after got=%h/%0d exp=00/1", flush, retired_cnt); end
        checks++; if (commit_en !== 2'b11) begin failures++; $display("FAIL ale_resume got=%b exp=11", commit_en); end
        clear_inputs();
        $display("test_exc_slot1 done");
    endtask

    task automatic test_brk_ipe();
        apply_reset();
        slot_valid = 2'b11; slot_pc = {32'h2004, 32'h2000}; slot_rf_we = 2'b11;
        set_exc(0, 4, 6'h0C, 9'h000);
        set_exc(1, 2, 6'h05, 9'h001);
        slot_priv = 2'b10; crmd_plv = 2'd3;
        #1;
        checks++; if (exc_ecode !== 6'h0C || exc_pc !== 32'h2000) begin failures++; $display("FAIL brk_cause got=%h/%h exp=0c/2000", exc_ecode, exc_pc); end
        checks++; if (commit_en !== 2'b00 || rf_we !== 2'b00) begin failures++; $display("FAIL brk_suppress got=%b/%b exp=00/00", commit_en, rf_we); end
        apply_reset();
        slot_valid = 2'b01; slot_pc = {32'h0, 32'h2100};
        set_exc(0, 2, 6'h07, 9'h003);
        slot_priv = 2'b01; crmd_plv = 2'd3;
        #1;
        checks++; if (exc_ecode !== 6'h0E || exc_esubcode !== 9'h000) begin failures++; $display("FAIL ipe_cause got=%h/%h exp=0e/000", exc_ecode, exc_esubcode); end
        crmd_plv = 2'd0;
        #1;
        checks++; if (exc_ecode !== 6'h07 || exc_esubcode !== 9'h003) begin failures++; $display("FAIL ipe_plv0 got=%h/%h exp=07/003", exc_ecode, exc_esubcode); end
        crmd_plv = 2'd3;
        set_exc(0, 5, 6'h08, 9'h000);
        #1;
        checks++; if (exc_ecode !== 6'h08) begin failures++; $display("FAIL exc_priority got=%h exp=08", exc_ecode); end
        clear_inputs();
        $display("test_brk_ipe done");
    endtask

    task automatic test_interrupt_run();
        apply_reset();
        slot_valid = 2'b01; slot_pc = {32'h0, 32'h2200};
        set_exc(0, 3, 6'h09, 9'h000);
        crmd_ie = 1'b1; ecfg_lie = 13'h004; estat_is = 13'h004;
        #1;
        checks++; if (exc_valid !== 1'b1 || exc_ecode !== 6'h00 || exc_pc !== 32'h2200) begin failures++; $display("FAIL int_override got=%b/%h/%h exp=1/00/2200", exc_valid, exc_ecode, exc_pc); end
        crmd_ie = 1'b0;
        #1;
        checks++; if (exc_ecode !== 6'h09) begin failures++; $display("FAIL int_ie_off got=%h exp=09", exc_ecode); end
        crmd_ie = 1'b1; ecfg_lie = 13'h002;
        #1;
        checks++; if (exc_ecode !== 6'h09) begin failures++; $display("FAIL int_masked got=%h exp=09", exc_ecode); end
        clear_inputs();
        $display("test_interrupt_run done");
    endtask

    task automatic test_ertn_branch();
        apply_reset();
        slot_valid = 2'b11; slot_pc = {32'h2404, 32'h2400}; slot_ertn = 2'b01;
        branch_flush = 1'b1; branch_target = 32'h0000_5000;
        #1;
        checks++; if (ertn_valid !== 1'b1 || commit_en !== 2'b01 || exc_valid !== 1'b0) begin failures++; $display("FAIL ertn_comb got=%b/%b/%b exp=1/01/0", ertn_valid, commit_en, exc_valid); end
        step();
        checks++; if (flush !== 8'hFF || new_pc !== ERA) begin failures++; $display("FAIL ertn_redirect got=%h/%h exp=ff/%h", flush, new_pc, ERA); end
        checks++; if (commit_en !== 2'b00 || retired_cnt !== 64'd1) begin failures++; $display("FAIL ertn_gate got=%b/%0d exp=00/1", commit_en, retired_cnt); end
        clear_inputs();
        step();
        checks++; if (flush !== 8'h00) begin failures++; $display("FAIL ertn_pulse got=%h exp=00", flush); end
        branch_flush = 1'b1; branch_target = 32'h0000_5000;
        step();
        checks++; if (flush !== 8'h7F || new_pc !== 32'h0000_5000) begin failures++; $display("FAIL branch_redirect got=%h/%h exp=7f/5000", flush, new_pc); end
        clear_inputs();
        step();
        checks++; if (flush !== 8'h00) begin failures++; $display("FAIL branch_pulse got=%h exp=00", flush); end
        $display("test_ertn_branch done");
    endtask

    task automatic test_idle();
        apply_reset();
        slot_valid = 2'b11; slot_pc = {32'h3004, 32'h3000}; slot_idle = 2'b01;
        #1;
        checks++; if (commit_en !== 2'b01 || exc_valid !== 1'b0) begin failures++; $display("FAIL idle_retire got=%b/%b exp=01/0", commit_en, exc_valid); end
        step();
        clear_inputs();
        slot_valid = 2'b11; ecfg_lie = 13'h004; estat_is = 13'h004;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (pause !== 8'hFF || commit_en !== 2'b00 || exc_valid !== 1'b0)
                begin failures++; $display("FAIL idle_wait_%0d got=%h/%b/%b exp=ff/00/0", c, pause, commit_en, exc_valid); end
            step();
        end
        crmd_ie = 1'b1;
        #1;
        checks++; if (exc_valid !== 1'b1 || exc_ecode !== 6'h00 || exc_pc !== 32'h3004) begin failures++; $display("FAIL idle_wake got=%b/%h/%h exp=1/00/3004", exc_valid, exc_ecode, exc_pc); end
        step();
        checks++; if (flush !== 8'hFF || new_pc !== EENTRY) begin failures++; $display("FAIL idle_redirect got=%h/%h exp=ff/%h", flush, new_pc, EENTRY); end
        checks++; if (retired_cnt !== 64'd1) begin failures++; $display("FAIL idle_cnt got=%0d exp=1", retired_cnt); end
        crmd_ie = 1'b0; slot_valid = 2'b00;
        step();
        slot_valid = 2'b11;
        #1;
        checks++; if (pause !== 8'h00 || commit_en !== 2'b11) begin failures++; $display("FAIL idle_run got=%h/%b exp=00/11", pause, commit_en); end
        clear_inputs();
        $display("test_idle done");
    endtask

    task automatic test_pause();
        apply_reset();
        slot_valid = 2'b11;
        pause_req = 7'b0100010;
        #1;
        checks++; if (pause !== 8'h3F || commit_en !== 2'b11) begin failures++; $display("FAIL pause_1_5 got=%h/%b exp=3f/11", pause, commit_en); end
        pause_req = 7'b1000000;
        set_exc(0, 1, 6'h02, 9'h000);
        #1;
        checks++; if (pause !== 8'h7F || commit_en !== 2'b00 || exc_valid !== 1'b0) begin failures++; $display("FAIL pause_6 got=%h/%b/%b exp=7f/00/0", pause, commit_en, exc_valid); end
        slot_exc = '0;
        pause_req = 7'b0000001;
        #1;
        checks++; if (pause !== 8'h01 || commit_en !== 2'b11) begin failures++; $display("FAIL pause_0 got=%h/%b exp=01/11", pause, commit_en); end
        clear_inputs();
        $display("test_pause done");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        slot_valid = 2'b01; slot_pc = {32'h0, 32'h4000};
        set_exc(0, 0, 6'h01, 9'h000);
        step();
        checks++; if (flush !== 8'hFF) begin failures++; $display("FAIL mid_flush got=%h exp=ff", flush); end
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (flush !== 8'h00 || new_pc !== 32'h0) begin failures++; $display("FAIL mid_async got=%h/%h exp=00/0", flush, new_pc); end
        #1 rst_n = 1'b1;
        step();
        slot_valid = 2'b11;
        #1;
        checks++; if (flush !== 8'h00 || commit_en !== 2'b11) begin failures++; $display("FAIL mid_run got=%h/%b exp=00/11", flush, commit_en); end
        clear_inputs();
        slot_valid = 2'b01; slot_pc = {32'h0, 32'h4100}; slot_idle = 2'b01;
        step();
        clear_inputs();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        checks++; if (pause !== 8'h00 || flush !== 8'h00) begin failures++; $display("FAIL mid_idle got=%h/%h exp=00/00", pause, flush); end
        $display("test_reset_mid done");
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        slot_valid = 2'b11;
        step();
        slot_valid = 2'b01;
        step();
        checks++; if (w_retired_cnt !== 2'd3 || retired_cnt !== 64'd3) begin failures++; $display("FAIL wrap_pre got=%0d/%0d exp=3/3", w_retired_cnt, retired_cnt); end
        step();
        checks++; if (w_retired_cnt !== 2'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", w_retired_cnt); end
        checks++; if (retired_cnt !== 64'd4) begin failures++; $display("FAIL wrap_wide got=%0d exp=4", retired_cnt); end
        clear_inputs();
        $display("test_cnt_wrap done");
    endtask

    initial begin
        test_reset();
        test_normal_commit();
        test_exc_slot1();
        test_brk_ipe();
        test_interrupt_run();
        test_ertn_branch();
        test_idle();
        test_pause();
        test_reset_mid();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
